mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_FIRST, default 1, 1 = data port wins simultaneous requests; 0 = round-robin on ties.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 inst_req  in  1  instruction-port request, held until inst_addr_ok.
REQ-005 inst_addr  in  32  instruction fetch address (read only).
REQ-006 inst_addr_ok / inst_data_ok  out  1 each  address-accepted / read-data-valid pulses.
REQ-007 inst_rdata  out  32  read data; valid when inst_data_ok=1.
REQ-008 data_req  in  1  data-port request, held until data_addr_ok.
REQ-009 data_wr  in  1  1 = store, 0 = load.
REQ-010 data_ben  in  4  byte enables.
REQ-011 data_addr, data_wdata  in  32 each  data address and store data.
REQ-012 data_addr_ok / data_data_ok  out  1 each  handshake pulses.
REQ-013 data_rdata  out  32  load data; valid when data_data_ok=1.
REQ-014 mem_req, mem_wr  out  1 each  shared bus request and write flag.
REQ-015 mem_ben  out  4;  mem_addr, mem_wdata  out  32 each.
REQ-016 mem_addr_ok, mem_data_ok  in  1 each;  mem_rdata  in  32.

Function
REQ-017 FSM states: IDLE, ADDR, DATA; exactly one bus transaction outstanding.
REQ-018 IDLE: if any request, grant owner, latch owner's wr/ben/addr/wdata into registers, go ADDR next cycle; otherwise stay.
REQ-019 Instruction grants latch wr=0, ben=4'b1111, wdata=0.
REQ-020 Tie, DATA_FIRST=1: data port granted; DATA_FIRST=0: port not granted last is granted (last_owner reset to inst, so data wins first tie).
REQ-021 ADDR: mem_req=1, mem_* driven from latched registers; hold until mem_addr_ok.
REQ-022 ADDR with mem_addr_ok=1: owner's *_addr_ok=1 same cycle (combinational), go DATA.
REQ-023 DATA: mem_req=0; on mem_data_ok=1 pulse owner's *_data_ok same cycle, go IDLE.
REQ-024 inst_rdata and data_rdata both = mem_rdata combinationally; only owner's data_ok asserts.
REQ-025 Non-owner addr_ok/data_ok stay 0; its request waits, held by master, no loss.
REQ-026 mem_data_ok in IDLE or ADDR ignored; mem_addr_ok outside ADDR ignored.
REQ-027 Minimum latency: request in cycle 0 -> mem_req cycle 1 -> data_ok earliest cycle 2; back-to-back throughput one transaction per 3 cycles.
REQ-028 Requester deasserting req before addr_ok is a protocol violation; latched transaction still completes.

Reset
REQ-029 rst=1 forces IDLE, owner=inst, last_owner=inst, latched registers 0.
REQ-030 During reset and in IDLE: mem_req=0, mem_wr=0, mem_ben=0, mem_addr=0, mem_wdata=0, all *_ok=0.
REQ-031 Reset mid-transaction abandons it with no data_ok; bus slave is reset by the same rst.

Structure
REQ-032 State encoding (IDLE/ADDR/DATA) and owner encoding (OWN_INST/OWN_DATA) in shared defines package.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 inst_req only, addr 0xBFC00000, addr_ok cycle 1, data_ok cycle 3 with 0x3C080001 -> inst_addr_ok cycle 1, inst_data_ok+rdata 0x3C080001 cycle 3, data_* ok stay 0.
REQ-035 Store: data_req, wr=1, ben=4'b0011, addr 0x00001000, wdata 0xDEADBEEF -> mem_wr=1, mem_ben=0011, mem_addr/wdata match while ADDR.
REQ-036 inst_req and data_req same cycle, DATA_FIRST=1 -> data served first, inst granted the cycle after data_data_ok, both complete.
REQ-037 DATA_FIRST=0, both requests held for 4 transactions -> grants alternate data, inst, data, inst.
REQ-038 Bus stalls addr_ok 5 cycles, then stray mem_data_ok in ADDR -> mem_req held 5 cycles, stray pulse ignored, no *_data_ok.
REQ-039 rst asserted in DATA -> next cycle IDLE, all outputs 0, later request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [3:0] BEN_ALL = 4'b1111;

    // One latched bus transaction, captured at grant time.
    typedef struct packed {
        logic        wr;
        logic [3:0]  ben;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory bus: one request/address phase, one data phase.
interface mem_arbiter_if;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_ben;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_ben, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_ben, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory bus with one
// transaction outstanding at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_ben,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    mem_arbiter_if.master mem
);

    state_t state;
    // owner keeps its value after a transaction completes, so it also acts
    // as the last-granted port for round-robin tie breaking.
    owner_t owner;
    xact_t  lat;
    xact_t  inst_x;
    xact_t  data_x;
    logic   grant_data;
    logic   in_addr;
    logic   in_data;

    assign inst_x = '{wr: 1'b0, ben: BEN_ALL, addr: inst_addr, wdata: 32'h0};
    assign data_x = '{wr: data_wr, ben: data_ben, addr: data_addr, wdata: data_wdata};

    // Pick the data port when it is alone, or when it wins a tie.
    always_comb begin
        grant_data = 1'b0;
        if (data_req && !inst_req)
            grant_data = 1'b1;
        else if (data_req && inst_req)
            grant_data = DATA_FIRST ? 1'b1 : (owner == OWN_INST);
    end

    // Arbitration FSM: grant and latch in IDLE, address phase, data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_INST;
            lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        owner <= grant_data ? OWN_DATA : OWN_INST;
                        lat   <= grant_data ? data_x : inst_x;
                        state <= ADDR;
                    end
                end
                ADDR:    if (mem.mem_addr_ok) state <= DATA;
                DATA:    if (mem.mem_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    // Bus drives the latched transaction only during the address phase.
    assign mem.mem_req   = in_addr;
    assign mem.mem_wr    = in_addr & lat.wr;
    assign mem.mem_ben   = in_addr ? lat.ben   : 4'h0;
    assign mem.mem_addr  = in_addr ? lat.addr  : 32'h0;
    assign mem.mem_wdata = in_addr ? lat.wdata : 32'h0;

    // Handshake pulses are steered to the current owner only.
    assign inst_addr_ok = in_addr & mem.mem_addr_ok & (owner == OWN_INST);
    assign data_addr_ok = in_addr & mem.mem_addr_ok & (owner == OWN_DATA);
    assign inst_data_ok = in_data & mem.mem_data_ok & (owner == OWN_INST);
    assign data_data_ok = in_data & mem.mem_data_ok & (owner == OWN_DATA);

    assign inst_rdata = mem.mem_rdata;
    assign data_rdata = mem.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: data-first instance with a stallable
// bus slave, plus a round-robin instance for tie alternation.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_ben = '0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    mem_arbiter_if bus();

    mem_arbiter #(.DATA_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_ben(data_ben),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem(bus)
    );

    // Round-robin instance with an always-ready slave.
    logic        r_inst_req = 1'b0, r_data_req = 1'b0;
    logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
    logic [31:0] r_inst_rdata, r_data_rdata;
    logic        r_in_data;

    mem_arbiter_if bus_rr();

    mem_arbiter #(.DATA_FIRST(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .inst_req(r_inst_req), .inst_addr(32'h0000_0100),
        .inst_addr_ok(r_inst_addr_ok), .inst_data_ok(r_inst_data_ok), .inst_rdata(r_inst_rdata),
        .data_req(r_data_req), .data_wr(1'b0), .data_ben(4'hF),
        .data_addr(32'h0000_0200), .data_wdata(32'h0),
        .data_addr_ok(r_data_addr_ok), .data_data_ok(r_data_data_ok), .data_rdata(r_data_rdata),
        .mem(bus_rr)
    );

    always_ff @(posedge clk) begin
        if (rst) r_in_data <= 1'b0;
        else     r_in_data <= bus_rr.mem_req && bus_rr.mem_addr_ok;
    end
    assign bus_rr.mem_addr_ok = bus_rr.mem_req;
    assign bus_rr.mem_data_ok = r_in_data;
    assign bus_rr.mem_rdata   = 32'h0;

    // Checking and scoreboard state.
    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          port;   // 1 = data port
        logic        wr;
        logic [3:0]  ben;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_bus[$];
    logic [31:0] exp_rd_i[$];
    logic [31:0] exp_rd_d[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C08_0001 : (a ^ 32'hA5A5_5A5A);
    endfunction

    // Bus slave: addr_ok after addr_delay stall cycles, data_ok after
    // data_delay cycles in the data phase, optional stray data_ok in ADDR.
    int          addr_delay = 0;
    int          data_delay = 0;
    bit          stray_en = 1'b0;
    logic        sl_in_data;
    int          wcnt, dcnt;
    logic [31:0] sl_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sl_in_data <= 1'b0;
            wcnt       <= 0;
            dcnt       <= 0;
            sl_addr    <= '0;
        end else if (!sl_in_data) begin
            if (bus.mem_req && bus.mem_addr_ok) begin
                sl_in_data <= 1'b1;
                sl_addr    <= bus.mem_addr;
                dcnt       <= 0;
                wcnt       <= 0;
            end else if (bus.mem_req) begin
                wcnt <= wcnt + 1;
            end
        end else if (bus.mem_data_ok) begin
            sl_in_data <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    assign bus.mem_addr_ok = bus.mem_req && !sl_in_data && (wcnt >= addr_delay);
    assign bus.mem_data_ok = (sl_in_data && (dcnt >= data_delay)) ||
                             (stray_en && bus.mem_req && (wcnt == 2));
    assign bus.mem_rdata   = sl_in_data ? rd_fn(sl_addr) : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop expected bus transactions on address accept and expected
    // read data on data completion.
    bit   mon_owner = 1'b0;
    int   aok_cyc[2];
    int   dok_cyc[2];
    int   last_stall = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req && bus.mem_addr_ok) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_exp_avail", 32'(exp_bus.size()), 1);
                end else begin
                    e = exp_bus.pop_front();
                    chk("grant_port", 32'({data_addr_ok, inst_addr_ok}), e.port ? 2 : 1);
                    chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
                    chk("mem_ben", 32'(bus.mem_ben), 32'(e.ben));
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
                end
                mon_owner          = data_addr_ok;
                aok_cyc[data_addr_ok] = cyc;
                last_stall         = wcnt;
            end else if (inst_addr_ok || data_addr_ok) begin
                chk("stray_aok", 32'({inst_addr_ok, data_addr_ok}), 0);
            end
            if (bus.mem_data_ok && !sl_in_data)
                chk("stray_dok", 32'({inst_data_ok, data_data_ok}), 0);
            if (bus.mem_data_ok && sl_in_data) begin
                chk("dok_port", 32'({data_data_ok, inst_data_ok}), mon_owner ? 2 : 1);
                if (mon_owner) begin
                    if (exp_rd_d.size() == 0) chk("data_rd_avail", 32'(exp_rd_d.size()), 1);
                    else chk("data_rdata", data_rdata, exp_rd_d.pop_front());
                end else begin
                    if (exp_rd_i.size() == 0) chk("inst_rd_avail", 32'(exp_rd_i.size()), 1);
                    else chk("inst_rdata", inst_rdata, exp_rd_i.pop_front());
                end
                dok_cyc[mon_owner] = cyc;
            end
        end
    end

    task automatic exp_push(input bit port, input logic wr, input logic [3:0] ben,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        x.port = port; x.wr = wr; x.ben = ben; x.addr = addr; x.wdata = wdata;
        exp_bus.push_back(x);
        if (port) exp_rd_d.push_back(rd_fn(addr));
        else      exp_rd_i.push_back(rd_fn(addr));
    endtask

    task automatic inst_go(input logic [31:0] a);
        int n = 0;
        inst_addr = a;
        inst_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!inst_addr_ok && n < 200);
        chk("inst_aok_seen", 32'(inst_addr_ok), 1);
        inst_req = 1'b0;
    endtask

    task automatic data_go(input logic wr, input logic [3:0] ben,
                           input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        data_wr = wr; data_ben = ben; data_addr = a; data_wdata = wd;
        data_req = 1'b1;
        do begin @(negedge clk); n++; end while (!data_addr_ok && n < 200);
        chk("data_aok_seen", 32'(data_addr_ok), 1);
        data_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_bus.size() + exp_rd_i.size() + exp_rd_d.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_bus.size() + exp_rd_i.size() + exp_rd_d.size()), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 32'({bus.mem_req, bus.mem_wr, bus.mem_ben}), 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_ok"}, 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int got;
        int dk;
        int n;
        int rr_seq[4];

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // Lone instruction fetch: addr_ok in cycle 1, data_ok in cycle 3.
        addr_delay = 0; data_delay = 1;
        t0 = cyc;
        exp_push(1'b0, 1'b0, 4'hF, 32'hBFC0_0000, 32'h0);
        inst_go(32'hBFC0_0000);
        drain();
        chk("inst_aok_lat", 32'(aok_cyc[0] - t0), 1);
        chk("inst_dok_lat", 32'(dok_cyc[0] - t0), 3);
        @(negedge clk);
        chk_quiet("idle");

        // Partial-word store.
        data_delay = 0;
        exp_push(1'b1, 1'b1, 4'b0011, 32'h0000_1000, 32'hDEAD_BEEF);
        data_go(1'b1, 4'b0011, 32'h0000_1000, 32'hDEAD_BEEF);
        drain();
        @(negedge clk);

        // Simultaneous requests: data first, inst granted right after.
        exp_push(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h1234_5678);
        exp_push(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        fork
            data_go(1'b0, 4'hF, 32'h0000_2000, 32'h1234_5678);
            inst_go(32'h0000_0400);
        join
        drain();
        chk("tie_regrant", 32'(aok_cyc[0] - dok_cyc[1]), 2);
        @(negedge clk);

        // Address stall of 5 cycles with a stray data_ok during ADDR.
        addr_delay = 5; stray_en = 1'b1;
        exp_push(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
        data_go(1'b0, 4'hF, 32'h0000_3000, 32'h0);
        drain();
        chk("addr_stall", 32'(last_stall), 5);
        stray_en = 1'b0;
        @(negedge clk);

        // Mixed traffic with varying bus delays.
        for (int i = 0; i < 4; i++) begin
            addr_delay = i; data_delay = 3 - i;
            if (i % 2 == 1) begin
                exp_push(1'b0, 1'b0, 4'hF, 32'h0000_0800 + 32'(i * 4), 32'h0);
                inst_go(32'h0000_0800 + 32'(i * 4));
            end else begin
                exp_push(1'b1, 1'b1, 4'(1 << i), 32'h0000_4000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
                data_go(1'b1, 4'(1 << i), 32'h0000_4000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            end
            drain();
        end
        @(negedge clk);

        // Reset during the data phase abandons the transaction.
        addr_delay = 0; data_delay = 10;
        exp_push(1'b0, 1'b0, 4'hF, 32'h0000_0500, 32'h0);
        inst_go(32'h0000_0500);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset");
        exp_bus.delete(); exp_rd_i.delete(); exp_rd_d.delete();
        rst = 1'b0;
        data_delay = 0;
        repeat (3) @(negedge clk);
        chk_quiet("post_reset");
        exp_push(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
        data_go(1'b0, 4'hF, 32'h0000_0600, 32'h0);
        drain();

        // Round-robin instance: both requests held, grants must alternate.
        got = 0; dk = 0; n = 0;
        r_inst_req = 1'b1; r_data_req = 1'b1;
        while (got < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (r_inst_data_ok || r_data_data_ok) dk++;
            if (r_data_addr_ok)      begin rr_seq[got] = 1; got++; end
            else if (r_inst_addr_ok) begin rr_seq[got] = 0; got++; end
        end
        r_inst_req = 1'b0; r_data_req = 1'b0;
        chk("rr_count", 32'(got), 4);
        chk("rr_dok_count", 32'(dk), 3);
        chk("rr_rdata", r_inst_rdata | r_data_rdata, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_grant%0d", i), 32'(rr_seq[i]), (i % 2 == 0) ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
